tmds_channel_decoder: RTL and testbench

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

---
 rtl/tmds_channel_decoder.sv | 192 +++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: control-token word alignment, bitslip requests and 8b/10b data decode.
// Optional lock-loss counter output (loss_cnt) is enabled by defining TMDS_DEC_LOCKLOSS_CNT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// SEARCH    | counting consecutive control tokens; timeout requests a bitslip
// SLIP_WAIT | bitslip issued; deserializer settling, sym_in ignored for alignment
// LOCKED    | word boundary found; watchdog expects periodic control-token runs
module tmds_channel_decoder #(
    parameter int unsigned LOCK_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 1024,
    parameter int unsigned SLIP_SETTLE    = 16,
    parameter int unsigned WDOG_W         = 21
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] sym_in,
    output logic [7:0] data_out,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic       bitslip,
    output logic       aligned
`ifdef TMDS_DEC_LOCKLOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    localparam int unsigned SRCH_W   = $clog2(SEARCH_TIMEOUT + 1);
    localparam int unsigned SETTLE_W = $clog2(SLIP_SETTLE + 2);

    localparam logic [SRCH_W-1:0]   SRCH_LAST   = SRCH_W'(SEARCH_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE);
    localparam logic [7:0]          RUN_LAST    = 8'(LOCK_RUN - 1);
    localparam logic [WDOG_W-1:0]   WDOG_PRE    = ~(WDOG_W'(1));

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]          ctrl_run;
    logic [SRCH_W-1:0]   srch_cnt;
    logic [SETTLE_W-1:0] slip_cnt;
    logic [WDOG_W-1:0]   wdog;

    logic       is_ctrl;
    logic [1:0] ctrl_code;
    logic [7:0] q;
    logic [7:0] dec;
    logic [7:0] run_inc;
    logic       run_hit;

    logic [7:0] data_nxt;
    logic       de_nxt;
    logic [1:0] c_nxt;
    logic       bitslip_nxt;

    always_comb begin
        is_ctrl   = 1'b1;
        ctrl_code = 2'b00;
        case (sym_in)
            10'h354: ctrl_code = 2'b00;
            10'h0AB: ctrl_code = 2'b01;
            10'h154: ctrl_code = 2'b10;
            10'h2AB: ctrl_code = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        q      = sym_in[9] ? ~sym_in[7:0] : sym_in[7:0];
        dec    = 8'h00;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym_in[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    assign run_inc = is_ctrl ? (ctrl_run + 8'd1) : 8'd0;
    assign run_hit = is_ctrl && (ctrl_run == RUN_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock wins over the search timeout when both land on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: begin
                if (run_hit) begin
                    state_nxt = LOCKED;
                end else if (srch_cnt == SRCH_LAST) begin
                    state_nxt = SLIP_WAIT;
                end
            end
            SLIP_WAIT: begin
                if (slip_cnt == SETTLE_LAST) begin
                    state_nxt = SEARCH;
                end
            end
            LOCKED: begin
                if (!run_hit && (wdog == WDOG_PRE)) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Outputs follow the state being entered so de never leads or lags aligned.
    always_comb begin
        bitslip_nxt = (state == SEARCH) && (state_nxt == SLIP_WAIT);
        de_nxt      = !is_ctrl && (state_nxt == LOCKED);
        data_nxt    = de_nxt ? dec : 8'h00;
        c_nxt       = is_ctrl ? ctrl_code : {c1, c0};
    end

    // Every counter falls back to zero unless its state keeps running it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_run <= 8'd0;
            srch_cnt <= '0;
            slip_cnt <= '0;
            wdog     <= '0;
        end else begin
            ctrl_run <= 8'd0;
            srch_cnt <= '0;
            slip_cnt <= '0;
            wdog     <= '0;
            case (state)
                SEARCH: begin
                    if (state_nxt == SEARCH) begin
                        ctrl_run <= run_inc;
                        srch_cnt <= srch_cnt + SRCH_W'(1);
                    end
                end
                SLIP_WAIT: begin
                    if (state_nxt == SLIP_WAIT) begin
                        slip_cnt <= slip_cnt + SETTLE_W'(1);
                    end
                end
                LOCKED: begin
                    if ((state_nxt == LOCKED) && !run_hit) begin
                        ctrl_run <= run_inc;
                        wdog     <= wdog + WDOG_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out <= 8'h00;
            de       <= 1'b0;
            c0       <= 1'b0;
            c1       <= 1'b0;
            bitslip  <= 1'b0;
        end else begin
            data_out <= data_nxt;
            de       <= de_nxt;
            c0       <= c_nxt[0];
            c1       <= c_nxt[1];
            bitslip  <= bitslip_nxt;
        end
    end

    assign aligned = (state == LOCKED);

`ifdef TMDS_DEC_LOCKLOSS_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_cnt <= 8'h00;
        end else if ((state == LOCKED) && (state_nxt == SEARCH) && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: directed alignment scenarios plus random data
// decode checked against a behavioural model built from the token table and decode rule.
module tb_tmds_channel_decoder;

    localparam int WDOG_W = 6;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] sym_in = 10'h000;
    logic [7:0] data_out;
    logic       de;
    logic       c0;
    logic       c1;
    logic       bitslip;
    logic       aligned;
`ifdef TMDS_DEC_LOCKLOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [1:0] c_exp = 2'b00;
    logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    tmds_channel_decoder #(
        .LOCK_RUN      (8),
        .SEARCH_TIMEOUT(1024),
        .SLIP_SETTLE   (16),
        .WDOG_W        (WDOG_W)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .sym_in  (sym_in),
        .data_out(data_out),
        .de      (de),
        .c0      (c0),
        .c1      (c1),
        .bitslip (bitslip),
        .aligned (aligned)
`ifdef TMDS_DEC_LOCKLOSS_CNT_EN
        ,
        .loss_cnt(loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int tok_idx(input logic [9:0] s);
        for (int k = 0; k < 4; k++) begin
            if (toks[k] == s) return k;
        end
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        int q;
        int d;
        int b;
        q = int'(s) & 255;
        if (s[9]) q = q ^ 255;
        d = q & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((q >> i) ^ (q >> (i - 1))) & 1;
            if (!s[8]) b = b ^ 1;
            d = d | (b << i);
        end
        return 8'(d);
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] s;
        do s = 10'($urandom_range(0, 1023)); while (tok_idx(s) >= 0);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one symbol, then checks the registered outputs it produced.
    task automatic send(input logic [9:0] s, input bit al, input bit bs);
        int t;
        bit de_e;
        logic [7:0] d_e;
        sym_in = s;
        @(posedge clk);
        #1;
        t = tok_idx(s);
        if (t >= 0) c_exp = 2'(t);
        de_e = al && (t < 0);
        d_e  = de_e ? ref_decode(s) : 8'h00;
        chk("aligned", aligned, al);
        chk("de", de, de_e);
        chk("data_out", data_out, d_e);
        chk("c1c0", {c1, c0}, c_exp);
        chk("bitslip", bitslip, bs);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_de", de, 1'b0);
        chk("rst_c0", c0, 1'b0);
        chk("rst_c1", c1, 1'b0);
        chk("rst_bitslip", bitslip, 1'b0);
        chk("rst_aligned", aligned, 1'b0);
`ifdef TMDS_DEC_LOCKLOSS_CNT_EN
        chk("rst_loss_cnt", loss_cnt, 8'h00);
`endif
        c_exp = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Eight 0x354 tokens: lock on the eighth edge.
        for (int i = 0; i < 7; i++) send(10'h354, 1'b0, 1'b0);
        send(10'h354, 1'b1, 1'b0);

        send(10'h100, 1'b1, 1'b0);
        chk("sym100_data", data_out, 8'h00);
        send(10'h1FF, 1'b1, 1'b0);
        chk("sym1ff_data", data_out, 8'h01);
        chk("sym1ff_de", de, 1'b1);

        // Random token runs keep the watchdog fed while random data is decoded.
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 8; i++) send(toks[$urandom_range(0, 3)], 1'b1, 1'b0);
            for (int i = 0; i < int'($urandom_range(1, 30)); i++) send(rand_data(), 1'b1, 1'b0);
        end

        // Watchdog starvation: aligned drops 63 clocks after the last full run.
        send(10'h100, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send(toks[$urandom_range(0, 3)], 1'b1, 1'b0);
        for (int i = 1; i < 63; i++) send(rand_data(), 1'b1, 1'b0);
        send(rand_data(), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send(rand_data(), 1'b0, 1'b0);
`ifdef TMDS_DEC_LOCKLOSS_CNT_EN
        chk("loss_cnt_after_wdog", loss_cnt, 8'h01);
`endif

        // Misaligned stream (0x354 rotated by 3 = 0x2A6): bitslip at 1024 and 2065.
        do_reset();
        for (int e = 1; e <= 2073; e++) send(10'h2A6, 1'b0, (e == 1024) || (e == 2065));
        for (int e = 2074; e <= 2082; e++) send(10'h354, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send(10'h354, 1'b0, 1'b0);
        send(10'h354, 1'b1, 1'b0);

        // Reset while bitslip is high, then confirm a clean search from zero.
        do_reset();
        for (int e = 1; e <= 1024; e++) send(10'h2A6, 1'b0, e == 1024);
        chk("bitslip_before_reset", bitslip, 1'b1);
        do_reset();
        for (int e = 1; e <= 1024; e++) send(10'h2A6, 1'b0, e == 1024);

        // A data symbol breaks the run; only the second run of eight locks.
        do_reset();
        for (int i = 0; i < 7; i++) send(10'h2AB, 1'b0, 1'b0);
        send(10'h123, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send(10'h0AB, 1'b0, 1'b0);
        send(10'h0AB, 1'b1, 1'b0);
        chk("run_break_c1c0", {c1, c0}, 2'b01);
        chk("run_break_de", de, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
